snn_timestep_scheduler: RTL and testbench

Sequences inference runs on the spiking network core, one timestep at a time.
- Buffers host-supplied input spike frames.
- Presents one frame per timestep and pulses the network's input-ready strobe.
- Waits for the network's data-valid, then accumulates per-neuron output spike counts.
- Sits between the host/pin interface and the network core; holds off issuing while SPI configuration of the core is in progress.

---
 rtl/snn_sched_pkg.sv | 30 +++
 rtl/snn_frame_fifo.sv | 57 +++++
 rtl/snn_timestep_scheduler.sv | 158 +++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared definitions for the SNN timestep scheduler.
//   - sched_state_t : scheduler FSM states
//   - Def*          : default widths/sizes used as parameter defaults
//   - sat_inc()     : saturating +0/+1 helper for the per-neuron spike counters
package snn_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StIssue,
    StWaitValid,
    StDone
  } sched_state_t;

  localparam int unsigned DefNumInputs  = 8;
  localparam int unsigned DefNumOutputs = 8;
  localparam int unsigned DefFifoDepth  = 4;
  localparam int unsigned DefCntW       = 8;
  localparam int unsigned DefTimeoutCyc = 255;

  // Add one spike to a counter, never wrapping past limit.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input logic [31:0] limit);
    if (inc && (val < limit)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/snn_frame_fifo.sv
// Synchronous FIFO buffering host input spike frames.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   push, push_data : write request and frame; ignored when full
//   pop             : read request; ignored when empty
//   full, empty     : occupancy flags
//   head            : oldest stored frame (valid when !empty)
module snn_frame_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences inference runs on the spiking network core, one timestep at a time.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   start, num_steps               : begin a run of max(num_steps,1) timesteps (IDLE only)
//   cfg_busy                       : SPI configuration in progress; holds off frame issue
//   frame_valid/frame_ready/data   : host frame push handshake into the buffer
//   net_input_spikes/net_input_ready : frame and 1-cycle strobe to the network
//   net_data_valid/net_output_spikes : network result for the current timestep
//   spike_counts                   : saturating per-neuron counters, neuron i at [i*CNT_W +: CNT_W]
//   step_count                     : completed timesteps in current/last run
//   busy, done, timeout_err        : status; done pulses at run end, timeout_err is sticky
module snn_timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = DefNumInputs,
  parameter int unsigned NUM_OUTPUTS = DefNumOutputs,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   num_steps,
  input  logic                         cfg_busy,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [NUM_INPUTS-1:0]        frame_data,
  output logic [NUM_INPUTS-1:0]        net_input_spikes,
  output logic                         net_input_ready,
  input  logic                         net_data_valid,
  input  logic [NUM_OUTPUTS-1:0]       net_output_spikes,
  output logic [NUM_OUTPUTS*CNT_W-1:0] spike_counts,
  output logic [7:0]                   step_count,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int unsigned TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [31:0] CntMax   = 32'({CNT_W{1'b1}});
  // Last timeout-counter value seen in WAIT_VALID before giving up.
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

  sched_state_t                 state_q, state_d;
  logic [7:0]                   steps_q, steps_d;
  logic [7:0]                   step_q, step_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic                         err_q, err_d;
  logic [NUM_INPUTS-1:0]        spikes_q, spikes_d;
  logic [NUM_OUTPUTS*CNT_W-1:0] counts_q, counts_d;

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [NUM_INPUTS-1:0] fifo_head;

  // Gated by reset so every output reads 0 while reset is held.
  assign frame_ready = !fifo_full && !reset;
  // The only exit from ISSUE is to WAIT_VALID, so popping in ISSUE pops on that transition.
  assign fifo_pop    = (state_q == StIssue);

  snn_frame_fifo #(
    .WIDTH(NUM_INPUTS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (frame_valid && frame_ready),
    .push_data(frame_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    step_d   = step_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    spikes_d = spikes_q;
    counts_d = counts_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          steps_d  = (num_steps == 8'd0) ? 8'd1 : num_steps;
          step_d   = '0;
          counts_d = '0;
          err_d    = 1'b0;
          state_d  = StWaitFrame;
        end
      end
      StWaitFrame: begin
        if (!fifo_empty && !cfg_busy) begin
          // Load on entry so the frame is stable alongside the strobe.
          spikes_d = fifo_head;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWaitValid;
      end
      StWaitValid: begin
        // Valid takes priority over an expiring timeout on the same cycle.
        if (net_data_valid) begin
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            counts_d[i*CNT_W +: CNT_W] = CNT_W'(sat_inc(32'(counts_q[i*CNT_W +: CNT_W]),
                                                        net_output_spikes[i], CntMax));
          end
          step_d  = step_q + 8'd1;
          state_d = ((step_q + 8'd1) == steps_q) ? StDone : StWaitFrame;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      steps_q  <= '0;
      step_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      spikes_q <= '0;
      counts_q <= '0;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      step_q   <= step_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      spikes_q <= spikes_d;
      counts_q <= counts_d;
    end
  end

  assign net_input_spikes = spikes_q;
  assign net_input_ready  = (state_q == StIssue);
  assign spike_counts     = counts_q;
  assign step_count       = step_q;
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StDone);
  assign timeout_err      = err_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler. A second instance with 2-bit counters
// shares every input and is used to observe counter saturation.
module tb_snn_timestep_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_steps = '0;
  logic        cfg_busy = 1'b0;
  logic        frame_valid = 1'b0;
  logic [7:0]  frame_data = '0;
  logic        net_data_valid = 1'b0;
  logic [7:0]  net_output_spikes = '0;

  logic        frame_ready, net_input_ready, busy, done, timeout_err;
  logic [7:0]  net_input_spikes, step_count;
  logic [63:0] spike_counts;

  logic        sat_frame_ready, sat_net_input_ready, sat_busy, sat_done, sat_timeout_err;
  logic [7:0]  sat_net_input_spikes, sat_step_count;
  logic [15:0] sat_spike_counts;

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (net_input_ready) n_strobe <= n_strobe + 1;
    if (done) n_done <= n_done + 1;
  end

  snn_timestep_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .cfg_busy(cfg_busy),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .net_input_spikes(net_input_spikes), .net_input_ready(net_input_ready),
    .net_data_valid(net_data_valid), .net_output_spikes(net_output_spikes),
    .spike_counts(spike_counts), .step_count(step_count), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  snn_timestep_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .cfg_busy(cfg_busy),
    .frame_valid(frame_valid), .frame_ready(sat_frame_ready), .frame_data(frame_data),
    .net_input_spikes(sat_net_input_spikes), .net_input_ready(sat_net_input_ready),
    .net_data_valid(net_data_valid), .net_output_spikes(net_output_spikes),
    .spike_counts(sat_spike_counts), .step_count(sat_step_count), .busy(sat_busy),
    .done(sat_done), .timeout_err(sat_timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [7:0] d);
    frame_valid = 1'b1;
    frame_data  = d;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] n, output int c0);
    num_steps = n;
    start     = 1'b1;
    c0        = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input logic [7:0] exp, output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      if (net_input_ready) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_strobe_seen"}, 64'(at >= 0), 64'd1);
    chk({tag, "_frame"}, 64'(net_input_spikes), 64'(exp));
  endtask

  task automatic wait_done(input string tag, output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 64'(at >= 0), 64'd1);
  endtask

  task automatic give_valid(input logic [7:0] outs, input int delay);
    repeat (delay) @(negedge clk);
    net_data_valid    = 1'b1;
    net_output_spikes = outs;
    @(negedge clk);
    net_data_valid    = 1'b0;
    net_output_spikes = '0;
  endtask

  // Three frames, three valids; neuron0 spikes twice, neuron7 once.
  task automatic run_basic(input string tag);
    int c0, at, s0, d0;
    push_frame(8'h01);
    push_frame(8'h03);
    push_frame(8'h81);
    s0 = n_strobe;
    d0 = n_done;
    start_run(8'd3, c0);
    wait_strobe({tag, "_f0"}, 8'h01, at);
    chk({tag, "_latency"}, 64'(at - c0), 64'd2);
    give_valid(8'h01, 4);
    wait_strobe({tag, "_f1"}, 8'h03, at);
    give_valid(8'h01, 4);
    wait_strobe({tag, "_f2"}, 8'h81, at);
    give_valid(8'h80, 4);
    wait_done(tag, at);
    chk({tag, "_counts"}, spike_counts, 64'h0100_0000_0000_0002);
    chk({tag, "_sat_counts"}, 64'(sat_spike_counts), 64'h4002);
    chk({tag, "_steps"}, 64'(step_count), 64'd3);
    chk({tag, "_err"}, 64'(timeout_err), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_strobe_total"}, 64'(n_strobe - s0), 64'd3);
    chk({tag, "_done_total"}, 64'(n_done - d0), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int c0, c1, s, at, s0, d0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready_held", 64'(frame_ready), 64'd0);
    chk("rst_strobe", 64'(net_input_ready), 64'd0);
    chk("rst_spikes", 64'(net_input_spikes), 64'd0);
    chk("rst_counts", spike_counts, 64'd0);
    chk("rst_steps", 64'(step_count), 64'd0);
    chk("rst_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 64'(frame_ready), 64'd1);

    // Basic three-step run
    run_basic("s1");

    // cfg_busy holds off issue; num_steps=0 acts as 1; start while busy ignored
    push_frame(8'h55);
    cfg_busy = 1'b1;
    s0 = n_strobe;
    start_run(8'd0, c0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start     = 1'b1;
        num_steps = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    chk("s2_no_strobe_while_cfg", 64'(n_strobe - s0), 64'd0);
    chk("s2_busy", 64'(busy), 64'd1);
    cfg_busy = 1'b0;
    c1 = cyc;
    wait_strobe("s2", 8'h55, at);
    chk("s2_release_latency", 64'(at - c1), 64'd1);
    give_valid(8'h02, 4);
    wait_done("s2", at);
    chk("s2_steps", 64'(step_count), 64'd1);
    chk("s2_counts", spike_counts, 64'h0000_0000_0000_0100);
    chk("s2_err", 64'(timeout_err), 64'd0);
    @(negedge clk);

    // Timeout: no valid ever
    push_frame(8'h07);
    start_run(8'd2, c0);
    wait_strobe("s3", 8'h07, s);
    wait_done("s3", at);
    chk("s3_timeout_latency", 64'(at - s), 64'd256);
    chk("s3_err", 64'(timeout_err), 64'd1);
    chk("s3_steps", 64'(step_count), 64'd0);
    @(negedge clk);
    chk("s3_err_sticky", 64'(timeout_err), 64'd1);

    // FIFO full backpressure, then 5 saturating steps
    for (int i = 0; i < 4; i++) begin
      frame_valid = 1'b1;
      frame_data  = 8'hA0 + 8'(i);
      chk("s4_ready_fill", 64'(frame_ready), 64'd1);
      @(negedge clk);
    end
    chk("s4_ready_full", 64'(frame_ready), 64'd0);
    frame_data = 8'hA4;
    repeat (2) @(negedge clk);
    chk("s4_ready_still_full", 64'(frame_ready), 64'd0);
    start_run(8'd5, c0);
    chk("s4_err_cleared", 64'(timeout_err), 64'd0);
    wait_strobe("s4_f0", 8'hA0, s);
    @(negedge clk);
    chk("s4_ready_after_pop", 64'(frame_ready), 64'd1);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("s4_fifth_accepted", 64'(frame_ready), 64'd0);
    give_valid(8'hFF, 2);
    wait_strobe("s4_f1", 8'hA1, s);
    give_valid(8'hFF, 4);
    wait_strobe("s4_f2", 8'hA2, s);
    give_valid(8'hFF, 4);
    chk("s5_sat_at_3", 64'(sat_spike_counts), 64'hFFFF);
    chk("s5_mid_counts", spike_counts, 64'h0303_0303_0303_0303);
    wait_strobe("s4_f3", 8'hA3, s);
    give_valid(8'hFF, 4);
    wait_strobe("s4_f4", 8'hA4, s);
    give_valid(8'hFF, 4);
    wait_done("s4", at);
    chk("s4_counts", spike_counts, 64'h0505_0505_0505_0505);
    chk("s5_sat_final", 64'(sat_spike_counts), 64'hFFFF);
    chk("s4_steps", 64'(step_count), 64'd5);
    @(negedge clk);

    // Reset during WAIT_VALID, with an extra frame left in the buffer
    push_frame(8'h11);
    push_frame(8'h22);
    start_run(8'd2, c0);
    wait_strobe("s6", 8'h11, s);
    @(negedge clk);
    chk("s6_in_wait_valid", 64'(busy), 64'd1);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_counts", spike_counts, 64'd0);
    chk("s6_done", 64'(done), 64'd0);
    reset = 1'b0;
    #1;
    chk("s6_ready", 64'(frame_ready), 64'd1);
    repeat (2) @(negedge clk);
    chk("s6_no_done", 64'(n_done - d0), 64'd0);
    run_basic("s6r");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
